// File: rtl/cv32e40x_rf_pair_writer.sv
// rtl/cv32e40x_rf_pair_writer.sv - write-back sequencer for the register file write ports
// Presents 32-bit and 64-bit pair writes one cycle after acceptance, splitting pairs when only one port is usable.
module cv32e40x_rf_pair_writer #(
   parameter int DUAL_WRITE              = 1,
   parameter int REGFILE_NUM_WRITE_PORTS = 2
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     wb_valid_i,
   output logic                                     wb_ready_o,
   input  logic                                     wb_we_i,
   input  logic                                     wb_pair_i,
   input  logic [4:0]                               wb_addr_i,
   input  logic [63:0]                              wb_data_i,
   output logic                                     dualwrite_o,
   output logic [REGFILE_NUM_WRITE_PORTS-1:0][4:0]  waddr_o,
   output logic [REGFILE_NUM_WRITE_PORTS-1:0][31:0] wdata_o,
   output logic [REGFILE_NUM_WRITE_PORTS-1:0]       we_o,
   output logic                                     pend_valid_o,
   output logic [4:0]                               pend_addr_o,
   output logic                                     err_o
);

   typedef enum logic {IDLE = 1'b0, HI = 1'b1} state_e;

   state_e                                     state_q, state_d;
   logic [4:0]                                 hi_addr_q, hi_addr_d;
   logic [31:0]                                hi_data_q, hi_data_d;
   logic                                       dual_q, dual_d;
   logic [REGFILE_NUM_WRITE_PORTS-1:0][4:0]    waddr_q, waddr_d;
   logic [REGFILE_NUM_WRITE_PORTS-1:0][31:0]   wdata_q, wdata_d;
   logic [REGFILE_NUM_WRITE_PORTS-1:0]         we_q, we_d;
   logic                                       pend_valid_q, pend_valid_d;
   logic [4:0]                                 pend_addr_q, pend_addr_d;
   logic                                       err_q, err_d;
   logic                                       accept;

   assign wb_ready_o = !rst && (state_q == IDLE);
   assign accept     = wb_valid_i && wb_ready_o;

   always_comb begin
      state_d      = state_q;
      hi_addr_d    = hi_addr_q;
      hi_data_d    = hi_data_q;
      dual_d       = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      we_d         = '0;
      pend_valid_d = 1'b0;
      pend_addr_d  = pend_addr_q;
      err_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (wb_pair_i && wb_addr_i[0]) begin
                  err_d = 1'b1;
               end else if (wb_pair_i && (DUAL_WRITE != 0)) begin
                  dual_d     = wb_we_i;
                  waddr_d[0] = wb_addr_i;
                  waddr_d[1] = wb_addr_i ^ 5'd1;
                  wdata_d[0] = wb_data_i[31:0];
                  wdata_d[1] = wb_data_i[63:32];
                  we_d       = {wb_we_i, wb_we_i};
               end else begin
                  waddr_d[0] = wb_addr_i;
                  wdata_d[0] = wb_data_i[31:0];
                  we_d[0]    = wb_we_i;
                  // A non-writing pair retires immediately; only a real pair owes a high half.
                  if (wb_pair_i && wb_we_i) begin
                     state_d      = HI;
                     hi_addr_d    = wb_addr_i ^ 5'd1;
                     hi_data_d    = wb_data_i[63:32];
                     pend_valid_d = 1'b1;
                     pend_addr_d  = wb_addr_i ^ 5'd1;
                  end
               end
            end
         end
         HI: begin
            waddr_d[0] = hi_addr_q;
            wdata_d[0] = hi_data_q;
            we_d[0]    = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      for (int k = 0; k < REGFILE_NUM_WRITE_PORTS; k++) begin
         if (waddr_d[k] == 5'd0) we_d[k] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hi_addr_q    <= '0;
         hi_data_q    <= '0;
         dual_q       <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         we_q         <= '0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_addr_q    <= hi_addr_d;
         hi_data_q    <= hi_data_d;
         dual_q       <= dual_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         err_q        <= err_d;
      end
   end

   assign dualwrite_o  = dual_q;
   assign waddr_o      = waddr_q;
   assign wdata_o      = wdata_q;
   assign we_o         = we_q;
   assign pend_valid_o = pend_valid_q;
   assign pend_addr_o  = pend_addr_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_cv32e40x_rf_pair_writer.sv
// tb/tb_cv32e40x_rf_pair_writer.sv - directed and model-based checks of both write modes
// The d_ instance has DUAL_WRITE=1, the s_ instance splits pairs; request fields are shared.
module tb_cv32e40x_rf_pair_writer;

   logic clk = 1'b0;
   logic rst;
   logic v_d, v_s, we, pair;
   logic [4:0] addr;
   logic [63:0] data;

   logic d_ready, d_dual, d_pv, d_err;
   logic [1:0][4:0] d_waddr;
   logic [1:0][31:0] d_wdata;
   logic [1:0] d_we;
   logic [4:0] d_pa;
   logic s_ready, s_dual, s_pv, s_err;
   logic [1:0][4:0] s_waddr;
   logic [1:0][31:0] s_wdata;
   logic [1:0] s_we;
   logic [4:0] s_pa;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   cv32e40x_rf_pair_writer #(.DUAL_WRITE(1), .REGFILE_NUM_WRITE_PORTS(2)) u_dual (
      .clk(clk), .rst(rst), .wb_valid_i(v_d), .wb_ready_o(d_ready), .wb_we_i(we),
      .wb_pair_i(pair), .wb_addr_i(addr), .wb_data_i(data), .dualwrite_o(d_dual),
      .waddr_o(d_waddr), .wdata_o(d_wdata), .we_o(d_we), .pend_valid_o(d_pv),
      .pend_addr_o(d_pa), .err_o(d_err));

   cv32e40x_rf_pair_writer #(.DUAL_WRITE(0), .REGFILE_NUM_WRITE_PORTS(2)) u_split (
      .clk(clk), .rst(rst), .wb_valid_i(v_s), .wb_ready_o(s_ready), .wb_we_i(we),
      .wb_pair_i(pair), .wb_addr_i(addr), .wb_data_i(data), .dualwrite_o(s_dual),
      .waddr_o(s_waddr), .wdata_o(s_wdata), .we_o(s_we), .pend_valid_o(s_pv),
      .pend_addr_o(s_pa), .err_o(s_err));

   typedef struct {
      logic v, we, pair;
      logic [4:0] a;
      logic [63:0] d;
      logic dual;
      logic [4:0] wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [1:0] wen;
      logic err;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic w, input logic p, input logic [4:0] a, input logic [63:0] d);
      we = w; pair = p; addr = a; data = d;
   endtask

   // Packs the split instance's port 0 view: {we, addr, data, pend_valid, pend_addr, err}
   function automatic logic [127:0] s_view();
      return {s_we, s_waddr[0], s_wdata[0], s_pv, s_pa, s_err, s_dual};
   endfunction

   function automatic logic [127:0] s_exp(input logic [1:0] w, input logic [4:0] a, input logic [31:0] d,
                                          input logic pv, input logic [4:0] pa, input logic e);
      return {w, a, d, pv, pa, e, 1'b0};
   endfunction

   logic [31:0] rf_exp [32];
   logic [31:0] rf_act [32];
   int wr_exp, wr_act;

   task automatic run_random(input bit split, input int cycles);
      bit have;
      logic acc, rdy;
      for (int i = 0; i < 32; i++) begin rf_exp[i] = '0; rf_act[i] = '0; end
      wr_exp = 0; wr_act = 0; have = 0;
      for (int c = 0; c < cycles + 4; c++) begin
         if (!have && c < cycles && $urandom_range(0, 3) != 0) begin
            have = 1;
            req($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                {$urandom, $urandom});
            if (pair && $urandom_range(0, 5) != 0) addr[0] = 1'b0;
         end
         if (split) begin v_s = have; v_d = 0; end
         else begin v_d = have; v_s = 0; end
         rdy = split ? s_ready : d_ready;
         acc = have && rdy;
         step();
         if (acc) begin
            have = 0;
            if (!(pair && addr[0]) && we) begin
               if (addr != 0) begin rf_exp[addr] = data[31:0]; wr_exp++; end
               if (pair && (addr ^ 5'd1) != 0) begin rf_exp[addr ^ 5'd1] = data[63:32]; wr_exp++; end
            end
         end
         v_d = 0; v_s = 0;
         for (int k = 0; k < 2; k++) begin
            if (split ? s_we[k] : d_we[k]) begin
               rf_act[split ? s_waddr[k] : d_waddr[k]] = split ? s_wdata[k] : d_wdata[k];
               wr_act++;
            end
         end
      end
      for (int i = 0; i < 32; i++) chk($sformatf("rand%0d_x%0d", split, i), 128'(rf_act[i]), 128'(rf_exp[i]));
      chk($sformatf("rand%0d_wrcount", split), 128'(wr_act), 128'(wr_exp));
   endtask

   initial begin
      vt[0] = '{1, 1, 1, 5'd10, 64'hDEADBEEF_12345678, 1, 5'd10, 5'd11, 32'h12345678, 32'hDEADBEEF, 2'b11, 0};
      vt[1] = '{0, 1, 1, 5'd10, 64'h0, 0, 5'd10, 5'd11, 32'h12345678, 32'hDEADBEEF, 2'b00, 0};
      vt[2] = '{1, 1, 0, 5'd5, 64'h9999_CAFEF00D, 0, 5'd5, 5'd11, 32'hCAFEF00D, 32'hDEADBEEF, 2'b01, 0};
      vt[3] = '{1, 1, 1, 5'd0, 64'h0000AAAA_0000BBBB, 1, 5'd0, 5'd1, 32'h0000BBBB, 32'h0000AAAA, 2'b10, 0};
      vt[4] = '{1, 1, 1, 5'd7, 64'h1111_2222, 0, 5'd0, 5'd1, 32'h0000BBBB, 32'h0000AAAA, 2'b00, 1};
      vt[5] = '{0, 1, 1, 5'd7, 64'h1111_2222, 0, 5'd0, 5'd1, 32'h0000BBBB, 32'h0000AAAA, 2'b00, 0};
      vt[6] = '{1, 0, 0, 5'd3, 64'h33, 0, 5'd3, 5'd1, 32'h33, 32'h0000AAAA, 2'b00, 0};
      vt[7] = '{1, 1, 0, 5'd0, 64'h44, 0, 5'd0, 5'd1, 32'h44, 32'h0000AAAA, 2'b00, 0};

      rst = 1; v_d = 1; v_s = 1;
      req(1, 1, 5'd10, 64'hDEADBEEF_12345678);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rst_d_%0d", i), {d_we, d_pv, d_err, d_dual}, 5'b0);
         chk($sformatf("rst_s_%0d", i), {s_we, s_pv, s_err, s_dual}, 5'b0);
      end
      chk("rst_regs", {d_waddr, d_wdata, s_waddr, s_wdata}, '0);
      rst = 0; v_d = 0; v_s = 0;
      #1;
      chk("ready_after_rst", {d_ready, s_ready}, 2'b11);

      for (int i = 0; i < 8; i++) begin
         v_d = vt[i].v;
         req(vt[i].we, vt[i].pair, vt[i].a, vt[i].d);
         step();
         v_d = 0;
         chk($sformatf("vec%0d", i), {d_dual, d_waddr[0], d_waddr[1], d_wdata[0], d_wdata[1], d_we, d_err, d_pv},
             {vt[i].dual, vt[i].wa0, vt[i].wa1, vt[i].wd0, vt[i].wd1, vt[i].wen, vt[i].err, 1'b0});
      end
      step();
      chk("dual_idle", {d_we, d_dual, d_ready}, 4'b0001);

      // Split pair followed by a held single write
      v_s = 1; req(1, 1, 5'd10, 64'hDEADBEEF_12345678);
      #1; chk("split_rdy0", s_ready, 1'b1);
      step();
      req(1, 0, 5'd5, 64'h55555555);
      chk("split_lo", s_view(), s_exp(2'b01, 5'd10, 32'h12345678, 1, 5'd11, 0));
      chk("split_stall", s_ready, 1'b0);
      step();
      chk("split_hi", s_view(), s_exp(2'b01, 5'd11, 32'hDEADBEEF, 0, 5'd11, 0));
      chk("split_rdy1", s_ready, 1'b1);
      step();
      v_s = 0;
      chk("split_held", s_view(), s_exp(2'b01, 5'd5, 32'h55555555, 0, 5'd11, 0));
      step();
      chk("split_idle", s_view(), s_exp(2'b00, 5'd5, 32'h55555555, 0, 5'd11, 0));

      // Pair at x0: low half suppressed, high half lands in x1
      v_s = 1; req(1, 1, 5'd0, 64'h0000AAAA_0000BBBB);
      step(); v_s = 0;
      chk("x0_lo", s_view(), s_exp(2'b00, 5'd0, 32'h0000BBBB, 1, 5'd1, 0));
      step();
      chk("x0_hi", s_view(), s_exp(2'b01, 5'd1, 32'h0000AAAA, 0, 5'd1, 0));

      v_s = 1; req(1, 1, 5'd7, 64'h1);
      step(); v_s = 0;
      chk("odd_err", s_view(), s_exp(2'b00, 5'd1, 32'h0000AAAA, 0, 5'd1, 1));
      step();
      chk("odd_err_clr", s_view(), s_exp(2'b00, 5'd1, 32'h0000AAAA, 0, 5'd1, 0));

      // Reset while the high half is pending
      v_s = 1; req(1, 1, 5'd12, 64'h77777777_66666666);
      step(); v_s = 0;
      chk("rsthi_lo", s_view(), s_exp(2'b01, 5'd12, 32'h66666666, 1, 5'd13, 0));
      rst = 1;
      step();
      rst = 0;
      chk("rsthi_drop", s_view(), s_exp(2'b00, 5'd0, 32'h0, 0, 5'd0, 0));
      #1; chk("rsthi_idle", s_ready, 1'b1);
      step();
      chk("rsthi_nowrite", s_view(), s_exp(2'b00, 5'd0, 32'h0, 0, 5'd0, 0));

      run_random(1'b1, 300);
      run_random(1'b0, 300);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
